// File: rtl/reg_file_rw_if.sv
// reg_file_rw_if: write-back write port plus decode two-source read port of the register file
interface reg_file_rw_if #(
  parameter int XLEN    = 32,
  parameter int REG_IDX = 5
);
  logic [REG_IDX-1:0] regFileWriteIdx;
  logic [XLEN-1:0]    regFileWriteVal;
  logic               regFileWriteEn;
  logic               rd_valid;
  logic [REG_IDX-1:0] rs1_idx;
  logic [REG_IDX-1:0] rs2_idx;
  logic               rd_data_valid;
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;
  logic               regReady;
  modport master (
    output regFileWriteIdx, regFileWriteVal, regFileWriteEn, rd_valid, rs1_idx, rs2_idx,
    input  rd_data_valid, rs1_val, rs2_val, regReady
  );
  modport slave (
    input  regFileWriteIdx, regFileWriteVal, regFileWriteEn, rd_valid, rs1_idx, rs2_idx,
    output rd_data_valid, rs1_val, rs2_val, regReady
  );
endinterface

// File: rtl/reg_file_rw.sv
// reg_file_rw: register file with post-reset clear sequencer, registered read port and write forwarding
module reg_file_rw #(
  parameter int XLEN    = 32,
  parameter int REG_IDX = 5,
  parameter int AMT_REG = 32
) (
  input logic         clk,
  input logic         rst,
  reg_file_rw_if.slave bus
);
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;
  logic [0:0]         r_state;
  logic [REG_IDX-1:0] r_clr_cnt;
  logic [XLEN-1:0]    r_regs [AMT_REG];
  logic               r_rd_data_valid;
  logic [XLEN-1:0]    r_rs1_val;
  logic [XLEN-1:0]    r_rs2_val;
  logic               w_wr;
  logic [XLEN-1:0]    w_rs1;
  logic [XLEN-1:0]    w_rs2;
  assign w_wr = r_state == S_READY && bus.regFileWriteEn && bus.regFileWriteIdx != '0;
  // a write landing on the same edge as the read must be seen by the reader
  always_comb begin
    w_rs1 = bus.rs1_idx == '0 ? '0 :
            (w_wr && bus.regFileWriteIdx == bus.rs1_idx) ? bus.regFileWriteVal : r_regs[bus.rs1_idx];
    w_rs2 = bus.rs2_idx == '0 ? '0 :
            (w_wr && bus.regFileWriteIdx == bus.rs2_idx) ? bus.regFileWriteVal : r_regs[bus.rs2_idx];
  end
  // contents have no reset; the clear sequence zeroes them instead
  always_ff @(posedge clk) begin
    if (rst && r_state == S_CLEAR) r_regs[r_clr_cnt] <= '0;
    else if (rst && w_wr) r_regs[bus.regFileWriteIdx] <= bus.regFileWriteVal;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= S_CLEAR;
      r_clr_cnt       <= REG_IDX'(1);
      r_rd_data_valid <= 1'b0;
      r_rs1_val       <= '0;
      r_rs2_val       <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_cnt       <= r_clr_cnt + REG_IDX'(1);
      r_state         <= r_clr_cnt == REG_IDX'(AMT_REG - 1) ? S_READY : S_CLEAR;
      r_rd_data_valid <= 1'b0;
    end else begin
      r_rd_data_valid <= bus.rd_valid;
      r_rs1_val       <= bus.rd_valid ? w_rs1 : r_rs1_val;
      r_rs2_val       <= bus.rd_valid ? w_rs2 : r_rs2_val;
    end
  end
  assign bus.rd_data_valid = r_rd_data_valid;
  assign bus.rs1_val       = r_rs1_val;
  assign bus.rs2_val       = r_rs2_val;
  assign bus.regReady      = r_state == S_READY;
endmodule
